fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle fetch path: PC register, instruction-memory request issue, and a prefetch FIFO decoupling fetch from decode.
- Sits between IM (one-cycle registered read) and instr_dec.
- Adds backpressure, branch/jump redirect with flush, and halt-fetch stop, none of which the single-cycle PC has.
- Generalised in address width, instruction width and buffer depth.

Parameters:
- ADDR_W, 16, PC / IM address width; word addressed.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, PC value after reset.
- HLT_OPCODE, 4'hF, value of instr[INSTR_W-1:INSTR_W-4] that marks HLT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- im_rd_en  out  1  IM read request this cycle.
- im_addr  out  ADDR_W  IM address; meaningful only when im_rd_en=1.
- im_instr  in  INSTR_W  IM data; valid the cycle after a request.
- id_valid  out  1  FIFO head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  INSTR_W  head instruction.
- id_pc  out  ADDR_W  PC of the head instruction.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch address.
- hlt  out  1  sticky; HLT instruction consumed by decode.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO empty; in-flight flag cleared; halt_fetched=0.
  - im_rd_en=0, id_valid=0, hlt=0.
  - First request (im_addr=RESET_PC) is issued in the first cycle after release.
- Issue: im_rd_en=1 when all of the following hold:
  - !redirect, !halt_fetched, !hlt;
  - count + inflight < DEPTH, where count is evaluated before this cycle's pop and inflight is 1 bit.
- Addressing: im_addr=pc. On issue, pc <= pc+1, wrapping modulo 2^ADDR_W. The issued pc is held as the in-flight tag.
- Response: the cycle after an issue, im_instr together with the tag is pushed into the FIFO unless the response was squashed.
  - Squash occurs when redirect was asserted in that cycle or in the issue cycle.
  - Throughput is one instruction per cycle.
- Handshake:
  - Pop when id_valid & id_ready.
  - id_instr / id_pc are stable while id_valid=1 and id_ready=0.
  - Simultaneous push and pop in one cycle leaves count unchanged.
  - With an empty FIFO, a pushed entry becomes visible on id_valid the cycle after the push; there is no fall-through.
- Redirect (priority over every other event in the same cycle):
  - FIFO flushed; in-flight response dropped; pc <= redirect_pc; halt_fetched <= 0.
  - im_rd_en=0 in the redirect cycle; im_addr=redirect_pc in the following cycle.
  - A pop in the redirect cycle still occurs; the head was presented before the flush.
- Halt:
  - When a pushed instruction has its top nibble equal to HLT_OPCODE, halt_fetched <= 1 and issuing stops. Younger requests already in flight are dropped.
  - hlt <= 1 when the HLT entry is popped. hlt clears only on reset.
  - Redirect after hlt=1 has no effect.
- Full FIFO: no issue. The credit check guarantees no push is ever lost; overflow is impossible by construction. A bench assertion checks count<=DEPTH.
- Reset mid-operation: everything returns to reset values immediately, whatever is in flight.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cycles (32 bits) and flush_count (16 bits), both saturating and reset to 0.
  - stall_cycles increments on each cycle with id_valid=0 && !hlt.
  - flush_count increments on each redirect.
- Undefined: those ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package wisc_pkg holds:
  - opcode localparams (HLT_OPCODE default, others for instr_dec);
  - a struct typedef fetch_entry_t {instr, pc} parametrised via localparam widths.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with flush, push, pop and count.
- The top holds the PC, the in-flight/squash flag, halt logic and issue control.

Test Plan:
- Reset, IM holding instrs 0x1000..0x1007, id_ready=1 → im_addr 0,1,2,… on consecutive cycles; id_pc 0,1,2… at one per cycle from cycle 2 after release.
- id_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, then im_rd_en=0; after id_ready=1 the entries drain in order 0..3, none lost or duplicated.
- redirect=1 with redirect_pc=0x0040 while the FIFO holds 3 entries and one is in flight → the next id_valid shows id_pc=0x0040; no stale entry appears.
- Instr 0xF000 at address 5 → no issue beyond address 6; hlt rises the cycle after id_pc=5 is popped and stays 1; a later redirect does not clear it.
- HLT fetched at address 3, then redirect to 0x0010 before it is popped → hlt stays 0; fetch resumes at 0x0010.
- pc=0xFFFF with ADDR_W=16 → next im_addr=0x0000; rst_n pulsed low mid-stream → id_valid=0 and hlt=0 immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared opcode values and the fetch-buffer entry layout used by fetch and decode.
// Pure declarations: no latency, no flow control.
package wisc_pkg;

    localparam int FE_ADDR_W  = 16;
    localparam int FE_INSTR_W = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic [FE_INSTR_W-1:0] instr;
        logic [FE_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: IM request/response, decode valid/ready handshake, redirect and halt.
// No storage; master is the fetch unit, slave is the IM/decode environment.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               im_rd_en;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_instr;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               hlt;

    modport master (
        output im_rd_en, im_addr, id_valid, id_instr, id_pc, hlt,
        input  im_instr, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  im_rd_en, im_addr, id_valid, id_instr, id_pc, hlt,
        output im_instr, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO with flush; a push is visible at the head one cycle later (no fall-through).
// No internal overflow guard: the producer must keep pushes within the free space shown by count_o.
module fetch_fifo
    import wisc_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  entry_t                     push_dat_i,
    input  logic                       pop_i,
    output entry_t                     head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// PC + IM request issue + prefetch FIFO; IM data lands in the FIFO one cycle after issue, head visible the next.
// Issue stalls on credit (count+inflight), redirect and halt. FETCH_PERF_CNT_EN adds stall/flush counters.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]        HLT_OPCODE = OP_HLT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [15:0]   flush_count
`endif
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              halt_fetched_q, halt_fetched_d;
    logic              hlt_q, hlt_d;

    logic              redir, credit_ok, issue, push, pop, valid;
    logic              push_is_hlt, head_is_hlt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    entry_t            push_dat, head;

    // A request still in flight holds a slot even if it will later be squashed.
    assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok   = occupancy < (CNT_W+1)'(DEPTH);
    assign issue       = !bus.redirect && !halt_fetched_q && !hlt_q && credit_ok;
    assign redir       = bus.redirect && !hlt_q;
    assign push        = inflight_q && !redir && !halt_fetched_q;
    assign valid       = (count != '0);
    assign pop         = valid && bus.id_ready;
    assign push_dat    = '{instr: bus.im_instr, pc: tag_q};
    assign push_is_hlt = push && (bus.im_instr[INSTR_W-1 -: 4] == HLT_OPCODE);
    assign head_is_hlt = (head.instr[INSTR_W-1 -: 4] == HLT_OPCODE);

    always_comb begin
        pc_d           = pc_q;
        tag_d          = tag_q;
        inflight_d     = issue;
        halt_fetched_d = halt_fetched_q;
        hlt_d          = hlt_q | (pop & head_is_hlt);
        if (redir) begin
            pc_d           = bus.redirect_pc;
            halt_fetched_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d  = pc_q + ADDR_W'(1);
                tag_d = pc_q;
            end
            if (push_is_hlt) halt_fetched_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            tag_q          <= '0;
            inflight_q     <= 1'b0;
            halt_fetched_q <= 1'b0;
            hlt_q          <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            tag_q          <= tag_d;
            inflight_q     <= inflight_d;
            halt_fetched_q <= halt_fetched_d;
            hlt_q          <= hlt_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redir),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head),
        .count_o    (count)
    );

    // Gated so no request is visible while reset is held.
    assign bus.im_rd_en = issue & rst_n;
    assign bus.im_addr  = pc_q;
    assign bus.id_valid = valid;
    assign bus.id_instr = head.instr;
    assign bus.id_pc    = head.pc;
    assign bus.hlt      = hlt_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!valid && !hlt_q && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (redir && (flush_q != '1))            flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming/backpressure vectors plus
// hand-written redirect, halt, wrap and mid-stream reset sequences against a registered IM model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    fetch_unit #(
        .ADDR_W     (16),
        .INSTR_W    (16),
        .DEPTH      (4),
        .RESET_PC   (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    int hlt_addr = -1;
    int cmp_cnt  = 0;
    int err_cnt  = 0;

    // IM: one-cycle registered read; word at hlt_addr is a HLT, otherwise 0x1000|addr[11:0].
    always @(posedge clk) begin
        if (bus.im_rd_en) begin
            if (int'(bus.im_addr) == hlt_addr) bus.im_instr <= 16'hF000;
            else                               bus.im_instr <= 16'h1000 | {4'h0, bus.im_addr[11:0]};
        end
    end

    always @(negedge clk) begin
        if (rst_n && (dut.u_fifo.count_o > 3'd4)) begin
            err_cnt++;
            $display("FAIL fifo_count_bound: count %0d, limit 4", dut.u_fifo.count_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000");
        $fatal(1);
    end

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [15:0] addr;
        logic        v;
        logic [15:0] pc;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic r, input logic rd, input int a, input logic v, input int p);
        vec_t t;
        t.rdy  = r;
        t.rd   = rd;
        t.addr = 16'(a);
        t.v    = v;
        t.pc   = 16'(p);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the first cycle after release.
    task automatic do_reset;
        rst_n           = 1'b0;
        bus.id_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.id_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;

        // Cycle-by-cycle expectations from release: stream, 10-cycle stall, drain.
        vt[0]  = mk(1, 1, 0, 0, 0);
        vt[1]  = mk(1, 1, 1, 0, 0);
        vt[2]  = mk(1, 1, 2, 1, 0);
        vt[3]  = mk(1, 1, 3, 1, 1);
        vt[4]  = mk(0, 1, 4, 1, 2);
        vt[5]  = mk(0, 1, 5, 1, 2);
        for (int i = 6; i < 14; i++) vt[i] = mk(0, 0, 0, 1, 2);
        vt[14] = mk(1, 0, 0, 1, 2);
        vt[15] = mk(1, 1, 6, 1, 3);
        vt[16] = mk(1, 1, 7, 1, 4);
        vt[17] = mk(1, 1, 8, 1, 5);
        vt[18] = mk(1, 1, 9, 1, 6);
        vt[19] = mk(1, 1, 10, 1, 7);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rd_en", 32'(bus.im_rd_en), 32'd0);
        chk("reset_valid", 32'(bus.id_valid), 32'd0);
        chk("reset_hlt",   32'(bus.hlt),      32'd0);

        // Table: streaming and backpressure
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.id_ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", i), 32'(bus.im_rd_en), 32'(vt[i].rd));
            if (vt[i].rd) chk($sformatf("vec%0d_addr", i), 32'(bus.im_addr), 32'(vt[i].addr));
            chk($sformatf("vec%0d_valid", i), 32'(bus.id_valid), 32'(vt[i].v));
            if (vt[i].v) begin
                chk($sformatf("vec%0d_pc", i), 32'(bus.id_pc), 32'(vt[i].pc));
                chk($sformatf("vec%0d_instr", i), 32'(bus.id_instr), 32'(16'h1000 | vt[i].pc));
            end
            tick();
        end

        // Redirect with 3 entries buffered and one in flight
        do_reset();
        repeat (4) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        @(negedge clk);
        chk("redir_rd_en_low", 32'(bus.im_rd_en), 32'd0);
        chk("redir_head_pre",  32'(bus.id_pc),    32'd0);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("redir_new_addr", 32'(bus.im_addr),  32'h0040);
        chk("redir_new_rd",   32'(bus.im_rd_en), 32'd1);
        chk("redir_flushed",  32'(bus.id_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("redir_no_stale", 32'(bus.id_valid), 32'd0);
        tick();
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("redir_valid", 32'(bus.id_valid), 32'd1);
        chk("redir_pc",    32'(bus.id_pc),    32'h0040);
        tick();
        @(negedge clk);
        chk("redir_pc_next", 32'(bus.id_pc), 32'h0041);

        // HLT at address 5
        hlt_addr = 5;
        do_reset();
        bus.id_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("halt_last_addr", 32'(bus.im_addr),  32'd6);
        chk("halt_last_rd",   32'(bus.im_rd_en), 32'd1);
        tick();
        @(negedge clk);
        chk("halt_stop_rd",   32'(bus.im_rd_en), 32'd0);
        chk("halt_head_pc",   32'(bus.id_pc),    32'd5);
        chk("halt_head_ins",  32'(bus.id_instr), 32'hF000);
        chk("halt_hlt_pre",   32'(bus.hlt),      32'd0);
        tick();
        @(negedge clk);
        chk("halt_hlt_set",   32'(bus.hlt),      32'd1);
        chk("halt_empty",     32'(bus.id_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("halt_idle%0d", i), 32'(bus.im_rd_en), 32'd0);
        end
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0010;
        @(negedge clk);
        chk("halt_redir_rd", 32'(bus.im_rd_en), 32'd0);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("halt_redir_hlt", 32'(bus.hlt),      32'd1);
        chk("halt_redir_rd2", 32'(bus.im_rd_en), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("halt_rst_hlt", 32'(bus.hlt), 32'd0);

        // HLT at address 3 flushed by redirect before it is popped
        hlt_addr = 3;
        do_reset();
        repeat (5) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0010;
        @(negedge clk);
        chk("hflush_rd", 32'(bus.im_rd_en), 32'd0);
        tick();
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("hflush_addr", 32'(bus.im_addr),  32'h0010);
        chk("hflush_rd2",  32'(bus.im_rd_en), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        chk("hflush_pc",    32'(bus.id_pc),    32'h0010);
        chk("hflush_instr", 32'(bus.id_instr), 32'h1010);
        tick();
        @(negedge clk);
        chk("hflush_pc2", 32'(bus.id_pc), 32'h0011);
        chk("hflush_hlt", 32'(bus.hlt),   32'd0);

        // PC wrap and mid-stream reset
        hlt_addr = -1;
        do_reset();
        bus.id_ready = 1'b1;
        repeat (2) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        @(negedge clk);
        chk("wrap_redir_rd", 32'(bus.im_rd_en), 32'd0);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr_ffff", 32'(bus.im_addr), 32'hFFFF);
        tick();
        @(negedge clk);
        chk("wrap_addr_0000", 32'(bus.im_addr), 32'h0000);
        chk("wrap_rd",        32'(bus.im_rd_en), 32'd1);
        tick();
        @(negedge clk);
        chk("wrap_pc_ffff",  32'(bus.id_pc),    32'hFFFF);
        chk("wrap_ins_ffff", 32'(bus.id_instr), 32'h1FFF);
        tick();
        @(negedge clk);
        chk("wrap_pc_0000", 32'(bus.id_pc), 32'h0000);
        tick();
        chk("mid_valid_pre", 32'(bus.id_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.id_valid), 32'd0);
        chk("mid_rst_rd",    32'(bus.im_rd_en), 32'd0);
        chk("mid_rst_hlt",   32'(bus.hlt),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_addr", 32'(bus.im_addr),  32'h0000);
        chk("restart_rd",   32'(bus.im_rd_en), 32'd1);
        tick();
        @(negedge clk);
        chk("restart_valid0", 32'(bus.id_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("restart_valid1", 32'(bus.id_valid), 32'd1);
        chk("restart_pc",     32'(bus.id_pc),    32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
